// File: rtl/qspi_stream_ctrl.sv
// qspi_stream_ctrl
// Quad-SPI flash read sequencer for the RLE video decoder.
// On start it issues the read opcode, the 24-bit address and the dummy
// clocks, then streams nibble pairs from IO3..IO0 into a two-entry FIFO
// that feeds a valid/ready consumer. The SPI clock is paused in its low
// phase whenever the FIFO could not absorb another byte, so the flash
// transaction never has to be restarted under backpressure.
module qspi_stream_ctrl #(
    parameter logic [7:0]  CMD          = 8'h6B,
    parameter int unsigned DUMMY_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [23:0] addr,
    input  logic [1:0]  latency,
    output logic [7:0]  data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_clk,
    output logic        spi_mosi,
    output logic        spi_mosi_oe,
    input  logic [3:0]  spi_d_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA
    } state_t;

    localparam logic [7:0] LP_DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [30:0] r_shift;
    logic        r_spiClk;
    logic        r_csN;
    logic        r_mosi;
    logic        r_oe;
    logic        r_busy;

    logic [1:0]  r_inFlight;
    logic [2:0]  r_capPipe;
    logic        r_nibSel;
    logic [3:0]  r_hiNib;
    logic [7:0]  r_fifoData0;
    logic [7:0]  r_fifoData1;
    logic        r_fifoValid0;
    logic        r_fifoValid1;

    logic        w_rise;
    logic        w_capture;
    logic        w_push;
    logic [7:0]  w_pushData;
    logic        w_pop;
    logic [2:0]  w_load;
    logic        w_room;
    logic        w_byteStart;

    assign w_rise      = (r_state == S_DATA) && r_spiClk;
    assign w_push      = w_capture && r_nibSel;
    assign w_pushData  = {r_hiNib, spi_d_in};
    assign w_pop       = r_fifoValid0 && data_ready;
    assign w_load      = 3'(r_fifoValid0) + 3'(r_fifoValid1) + 3'(r_inFlight);
    assign w_room      = (w_load <= 3'd1);
    assign w_byteStart = (r_state == S_DATA) && !r_spiClk && !r_cnt[0] && w_room;

    // Pick the capture strobe that lags the SPI rising edge by 'latency' clocks
    always_comb begin
        w_capture = w_rise;
        case (latency)
            2'd0:    w_capture = w_rise;
            2'd1:    w_capture = r_capPipe[0];
            2'd2:    w_capture = r_capPipe[1];
            default: w_capture = r_capPipe[2];
        endcase
    end

    // Transaction sequencer: drives chip select, SPI clock phase and IO0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_shift  <= 31'd0;
            r_spiClk <= 1'b0;
            r_csN    <= 1'b1;
            r_mosi   <= 1'b0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
        end else if (stop) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_spiClk <= 1'b0;
            r_csN    <= 1'b1;
            r_mosi   <= 1'b0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_CMD;
                        r_cnt    <= 8'd0;
                        r_shift  <= {CMD[6:0], addr};
                        r_mosi   <= CMD[7];
                        r_oe     <= 1'b1;
                        r_csN    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_spiClk <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (!r_spiClk) begin
                        if (r_cnt[0] || w_room) begin
                            r_spiClk <= 1'b1;
                        end
                    end else begin
                        r_spiClk <= 1'b0;
                        r_cnt    <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    if (!r_spiClk) begin
                        r_spiClk <= 1'b1;
                    end else begin
                        r_spiClk <= 1'b0;
                        if (r_state != S_DUMMY) begin
                            r_mosi  <= r_shift[30];
                            r_shift <= {r_shift[29:0], 1'b0};
                        end
                        if (r_state == S_CMD && r_cnt == 8'd7) begin
                            r_state <= S_ADDR;
                            r_cnt   <= 8'd0;
                        end else if (r_state == S_ADDR && r_cnt == 8'd23) begin
                            r_state <= (DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
                            r_cnt   <= 8'd0;
                            r_oe    <= 1'b0;
                            r_mosi  <= 1'b0;
                        end else if (r_state == S_DUMMY && r_cnt == LP_DUMMY_LAST) begin
                            r_state <= S_DATA;
                            r_cnt   <= 8'd0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Nibble capture, in-flight byte accounting and the two-entry output FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_capPipe    <= 3'd0;
            r_nibSel     <= 1'b0;
            r_hiNib      <= 4'd0;
            r_inFlight   <= 2'd0;
            r_fifoData0  <= 8'd0;
            r_fifoData1  <= 8'd0;
            r_fifoValid0 <= 1'b0;
            r_fifoValid1 <= 1'b0;
        end else if (stop) begin
            r_capPipe    <= 3'd0;
            r_nibSel     <= 1'b0;
            r_inFlight   <= 2'd0;
            r_fifoData0  <= 8'd0;
            r_fifoValid0 <= 1'b0;
            r_fifoValid1 <= 1'b0;
        end else begin
            r_capPipe  <= {r_capPipe[1:0], w_rise};
            r_inFlight <= r_inFlight + 2'(w_byteStart) - 2'(w_push);
            if (w_capture) begin
                if (!r_nibSel) begin
                    r_hiNib  <= spi_d_in;
                    r_nibSel <= 1'b1;
                end else begin
                    r_nibSel <= 1'b0;
                end
            end
            case ({w_push, w_pop})
                2'b10: begin
                    if (!r_fifoValid0) begin
                        r_fifoData0  <= w_pushData;
                        r_fifoValid0 <= 1'b1;
                    end else begin
                        r_fifoData1  <= w_pushData;
                        r_fifoValid1 <= 1'b1;
                    end
                end
                2'b01: begin
                    r_fifoData0  <= r_fifoData1;
                    r_fifoValid0 <= r_fifoValid1;
                    r_fifoValid1 <= 1'b0;
                end
                2'b11: begin
                    if (r_fifoValid1) begin
                        r_fifoData0 <= r_fifoData1;
                        r_fifoData1 <= w_pushData;
                    end else begin
                        r_fifoData0 <= w_pushData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data        = r_fifoData0;
    assign data_valid  = r_fifoValid0;
    assign busy        = r_busy;
    assign spi_cs_n    = r_csN;
    assign spi_clk     = r_spiClk;
    assign spi_mosi    = r_mosi;
    assign spi_mosi_oe = r_oe;

endmodule
